// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the output pixel memory
package dmem_pkg;

    localparam int PIX_W      = 8;
    localparam int IMG_AMOUNT = 90000;
    localparam int OUT_BASE   = 302;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND
    } dump_state_t;

    // Bits needed to index n pixels; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/d_out_mem_ram.sv
// rtl/d_out_mem_ram.sv - single-port synchronous pixel RAM with registered read
module out_ram #(
    parameter int PIXEL  = 8,
    parameter int AMOUNT = 90000,
    parameter int AW     = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIXEL-1:0] wd,
    output logic [PIXEL-1:0] q
);
    logic [PIXEL-1:0] mem [AMOUNT];

    // Storage array is deliberately not reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wd;
        end
    end

    // Read-first output register: a same-address write returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/d_out_mem.sv
// rtl/d_out_mem.sv - output pixel memory with mapped write port and streaming dump
module d_out_mem
    import dmem_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter int AMOUNT = IMG_AMOUNT,
    parameter int PIXEL  = PIX_W,
    parameter int BASE   = OUT_BASE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] rd,
    input  logic             dump_start,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [PIXEL-1:0] dump_data,
    output logic             dump_last,
    output logic             busy,
    output logic             wr_err
);
    localparam int             IW       = idx_width(AMOUNT);
    localparam logic [WIDTH:0] LO       = (WIDTH+1)'(BASE);
    localparam logic [WIDTH:0] HI       = (WIDTH+1)'(BASE + AMOUNT);
    localparam logic [IW-1:0]  LAST_IDX = IW'(AMOUNT - 1);

    dump_state_t      state;
    logic [IW-1:0]    ptr;
    logic [WIDTH-1:0] off;
    logic [IW-1:0]    idx;
    logic             in_range;
    logic             ram_we;
    logic [IW-1:0]    ram_addr;
    logic [PIXEL-1:0] q;
    logic             rd_range_q;
    logic             hold_active;
    logic [PIXEL-1:0] hold_pix;
    logic [PIXEL-1:0] live_pix;
    logic             unused_bits;

    // Range test is done one bit wider than the bus so BASE+AMOUNT cannot wrap.
    assign in_range = ({1'b0, a} >= LO) && ({1'b0, a} < HI);
    assign off      = a - WIDTH'(BASE);
    assign idx      = off[IW-1:0];
    assign ram_we   = we && !busy && in_range;
    // The dump engine owns the RAM port for the whole time it is busy.
    assign ram_addr = busy ? ptr : idx;

    // rd shows the live readback normally and a snapshot while the dump owns the RAM.
    assign live_pix  = rd_range_q ? q : '0;
    assign rd        = WIDTH'(hold_active ? hold_pix : live_pix);
    assign dump_data = dump_valid ? q : '0;

    assign unused_bits = ^{wd[WIDTH-1:PIXEL], off[WIDTH-1:IW]};

    out_ram #(
        .PIXEL  (PIXEL),
        .AMOUNT (AMOUNT),
        .AW     (IW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .addr  (ram_addr),
        .wd    (wd[PIXEL-1:0]),
        .q     (q)
    );

    // Sticky flag for any write that could not land in the RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else if (we && (busy || !in_range)) begin
            wr_err <= 1'b1;
        end
    end

    // Track readback range and freeze rd one cycle into a dump, before ptr reads reach q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_range_q  <= 1'b0;
            hold_active <= 1'b0;
            hold_pix    <= '0;
        end else begin
            hold_active <= busy;
            if (busy && !hold_active) begin
                hold_pix <= live_pix;
            end
            if (!busy) begin
                rd_range_q <= in_range;
            end
        end
    end

    // Dump engine: one FETCH cycle to load q with RAM[ptr], then SEND until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            busy       <= 1'b0;
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dump_start) begin
                        state <= ST_FETCH;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state      <= ST_SEND;
                    dump_valid <= 1'b1;
                    dump_last  <= (ptr == LAST_IDX);
                end
                ST_SEND: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        dump_last  <= 1'b0;
                        if (ptr == LAST_IDX) begin
                            state <= ST_IDLE;
                            ptr   <= '0;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_FETCH;
                            ptr   <= ptr + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    dump_valid <= 1'b0;
                    dump_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_d_out_mem.sv
// tb/tb_d_out_mem.sv - self-checking bench for d_out_mem with a dump scoreboard
module tb_d_out_mem;
    localparam int W = 24;
    localparam int A = 300;
    localparam int P = 8;
    localparam int B = 302;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         we;
    logic [W-1:0] a;
    logic [W-1:0] wd;
    logic [W-1:0] rd;
    logic         dump_start;
    logic         dump_valid;
    logic         dump_ready;
    logic [P-1:0] dump_data;
    logic         dump_last;
    logic         busy;
    logic         wr_err;

    int           checks   = 0;
    int           failures = 0;
    int           beats    = 0;
    int           n;
    logic [P-1:0] mdl [A];
    logic [P-1:0] exp_q [$];
    logic [P-1:0] mon_pix;

    always #5 clk = ~clk;

    d_out_mem #(
        .WIDTH  (W),
        .AMOUNT (A),
        .PIXEL  (P),
        .BASE   (B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we),
        .a          (a),
        .wd         (wd),
        .rd         (rd),
        .dump_start (dump_start),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .busy       (busy),
        .wr_err     (wr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [W-1:0] data);
        a  = W'(addr);
        wd = data;
        we = 1'b1;
        tick();
        we = 1'b0;
        if (addr >= B && addr < B + A) mdl[addr - B] = data[P-1:0];
    endtask

    task automatic rdchk(input string tag, input int addr, input logic [31:0] exp);
        a  = W'(addr);
        we = 1'b0;
        tick();
        chk(tag, rd, exp);
    endtask

    task automatic load_exp();
        exp_q.delete();
        for (int i = 0; i < A; i++) exp_q.push_back(mdl[i]);
        beats = 0;
    endtask

    task automatic start_dump();
        load_exp();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 3 * A) begin
            tick();
            k++;
        end
        chk(tag, busy, 0);
        chk({tag, "_queue"}, exp_q.size(), 0);
        chk({tag, "_beats"}, beats, A);
    endtask

    task automatic wait_beats(input string tag, input int target);
        int k;
        k = 0;
        while (beats < target && k < 4 * A) begin
            tick();
            k++;
        end
        chk(tag, beats, target);
    endtask

    // Scoreboard: every accepted beat is popped and compared in order.
    always @(negedge clk) begin
        if (rst_n && dump_valid && dump_ready) begin
            chk("beat_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_pix = exp_q.pop_front();
                chk("dump_data", dump_data, mon_pix);
                chk("dump_last", dump_last, exp_q.size() == 0);
            end
            beats++;
        end
    end

    initial begin
        rst_n      = 1'b0;
        we         = 1'b0;
        a          = '0;
        wd         = '0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
        repeat (2) tick();
        chk("rst_rd", rd, 0);
        chk("rst_valid", dump_valid, 0);
        chk("rst_data", dump_data, 0);
        chk("rst_last", dump_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_err", wr_err, 0);
        rst_n = 1'b1;
        tick();

        wr(B, 'hA5);
        rdchk("rd_a5", B, 'hA5);
        chk("wr_err_clean", wr_err, 0);
        wr(B + A - 1, 'h5A);
        rdchk("rd_top", B + A - 1, 'h5A);
        chk("wr_err_top", wr_err, 0);
        wr(B - 1, 'h99);
        chk("wr_err_low", wr_err, 1);
        rdchk("rd_below", B - 1, 0);
        wr(B + A, 'h99);
        rdchk("rd_above", B + A, 0);
        wr(B + 512, 'h77);
        rdchk("no_wrap", B, 'hA5);
        rdchk("rd_top_kept", B + A - 1, 'h5A);
        wr(500, 'hFFFF3C);
        rdchk("rd_trunc", 500, 'h3C);

        a  = W'(500);
        wd = 'h11;
        we = 1'b1;
        tick();
        we = 1'b0;
        mdl[500 - B] = 8'h11;
        chk("rw_old", rd, 'h3C);
        rdchk("rw_new", 500, 'h11);

        for (int i = 0; i < A; i++) wr(B + i, W'(i % 256));

        mdl[0] = 8'hC3;
        load_exp();
        dump_ready = 1'b1;
        dump_start = 1'b1;
        we         = 1'b1;
        a          = W'(B);
        wd         = 'hC3;
        tick();
        dump_start = 1'b0;
        we         = 1'b0;
        a          = W'(B + A - 1);
        n          = 1;
        chk("start_busy", busy, 1);
        chk("start_no_valid", dump_valid, 0);
        while (n < 2 * A + 50) begin
            tick();
            n++;
            if (n == 100) chk("rd_hold", rd, 0);
            if (!busy) break;
        end
        chk("dump_cycles", n, 2 * A + 1);
        chk("dump1_queue", exp_q.size(), 0);
        chk("dump1_beats", beats, A);
        tick();
        chk("rd_after_dump", rd, 'h2B);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("wr_err_cleared", wr_err, 0);
        start_dump();
        wait_beats("reach_px7", 7);
        dump_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", dump_valid, 1);
            chk("stall_data", dump_data, 7);
            chk("stall_last", dump_last, 0);
            if (i == 0) begin
                we = 1'b1;
                a  = W'(400);
                wd = 'hEE;
            end
            if (i == 1) begin
                we = 1'b0;
                chk("wr_err_busy", wr_err, 1);
            end
            if (i == 2) dump_start = 1'b1;
            if (i == 3) dump_start = 1'b0;
        end
        dump_ready = 1'b1;
        wait_idle("stall_dump");

        start_dump();
        wait_beats("reach_px100", 100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rd", rd, 0);
        chk("arst_valid", dump_valid, 0);
        chk("arst_data", dump_data, 0);
        chk("arst_last", dump_last, 0);
        chk("arst_busy", busy, 0);
        chk("arst_wr_err", wr_err, 0);
        exp_q.delete();
        tick();
        tick();
        chk("arst_hold_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_valid", dump_valid, 0);
        start_dump();
        wait_idle("restart_dump");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/d_out_mem.md
# d_out_mem

Output pixel memory for the vector processor: the store-side counterpart of the input pixel memory. The datapath writes processed 8-bit pixels through a memory-mapped write port at word addresses BASE..BASE+AMOUNT-1. After processing, a dump engine streams the whole image out in address order over a valid/ready handshake, for capture by the testbench or host link.

## Interface
- WIDTH, 24: datapath address/data width.
- AMOUNT, 90000: pixel count (300x300 image).
- PIXEL, 8: stored bits per pixel.
- BASE, 302: first mapped word address.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  datapath write enable.
- a  in  WIDTH  datapath word address.
- wd  in  WIDTH  write data; only wd[PIXEL-1:0] is stored.
- rd  out  WIDTH  registered readback, {16'b0, pixel}.
- dump_start  in  1  one-cycle request to stream the image.
- dump_valid  out  1  dump_data holds a pixel.
- dump_ready  in  1  sink accepts the beat.
- dump_data  out  PIXEL  streamed pixel.
- dump_last  out  1  marks pixel AMOUNT-1; valid only with dump_valid.
- busy  out  1  dump in progress.
- wr_err  out  1  sticky: out-of-range write or write dropped while busy.

## Operation
- Index idx = a - BASE, width ceil(log2(AMOUNT)). In range means BASE <= a < BASE+AMOUNT, compared at full WIDTH with no wrap.
- Write: when we is high, busy is low and a is in range, RAM[idx] <= wd[PIXEL-1:0] on the clock edge.
- Dropped writes: a write with we high and a out of range, or with busy high, is dropped and sets wr_err. wr_err is cleared only by reset.
- Readback: when not busy, rd <= in range ? {0, RAM[idx]} : 0 on each clock. rd holds its value while busy. A write and a readback to the same index in the same cycle return the old data.
- RAM contents are not reset. Contents are undefined until written.
- Dump FSM:
  - IDLE: busy=0. dump_start moves the FSM to FETCH with ptr=0. dump_start is ignored outside IDLE.
  - FETCH: issues the synchronous read of RAM[ptr], then moves to SEND.
  - SEND: dump_valid=1, and dump_data is the registered read value.
  - On dump_valid && dump_ready: if ptr==AMOUNT-1 (dump_last=1), go to IDLE; else ptr++ and go to FETCH.
  - Without ready, the FSM stays in SEND and dump_data and dump_last hold stable.
- dump_valid is never deasserted before the handshake completes.
- If dump_start and we are asserted in the same cycle in IDLE, the write is performed; the dump then starts and sees the written value.

## Timing
- Reset values: rd=0, dump_valid=0, dump_data=0, dump_last=0, busy=0, wr_err=0. The FSM returns to IDLE and ptr=0.
- Reset asserted mid-dump aborts the dump immediately; no further beats are produced.
- Write latency: data is in the RAM one cycle after the we edge.
- rd latency: 1 cycle.
- dump_start at edge N: busy=1 from N+1, dump_valid=1 from N+2 with pixel 0.
- With dump_ready held at 1, the dump produces one beat per 2 cycles. busy falls the cycle after the final handshake, for a total of 2*AMOUNT+1 cycles.

## Structure
- Package dmem_pkg holds:
  - the dump state enum (IDLE, FETCH, SEND);
  - constants PIX_W=8, IMG_AMOUNT=90000, OUT_BASE=302;
  - the idx width function.
- Sub-module out_ram: single-port synchronous RAM (PIXEL x AMOUNT) with we, addr, wd, and a registered q. The address mux selects between the datapath index and ptr based on busy.

## Test plan
- Write 0xA5 to a=302, then read a=302 → rd=0x0000A5 one cycle later. Write at a=90301 → stored; a=301 and a=90302 → dropped, wr_err=1.
- wd=0xFFFF3C at a=500 → rd=0x00003C (upper bits discarded).
- Fill the pattern idx mod 256, pulse dump_start with dump_ready=1 → 90000 beats in order, dump_last only on the beat carrying 0x8F (89999 mod 256), busy low after 180001 cycles.
- Hold dump_ready=0 for 5 cycles at pixel 7 → dump_valid stays 1 with data 7 stable; pixel 8 follows only after ready.
- we with a=400 while busy → RAM unchanged (a later dump shows the old value), wr_err=1. A second dump_start mid-dump → ignored.
- rst_n low during beat 1000 → all outputs 0 asynchronously, busy=0. A new dump_start then restarts from pixel 0.
